// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: selects the round input, XORs it with the round key and
// holds results in a two-entry skid buffer while tracking the 0..LAST_ROUND round sequence.
module add_round_key_stage #(
    parameter int DATA_W     = 128,
    parameter int LAST_ROUND = 10
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic [DATA_W-1:0] iInText,
    input  logic [DATA_W-1:0] iMixText,
    input  logic [DATA_W-1:0] iShiftText,
    input  logic [DATA_W-1:0] iRoundKey,
    input  logic [3:0]        iRound,
    input  logic              iValid,
    output logic              oReady,
    output logic [DATA_W-1:0] oRoundText,
    output logic [3:0]        oRound,
    output logic              oValid,
    input  logic              iReady,
    output logic              oDone,
    output logic              oRoundErr
);

    localparam logic [3:0] LAST = 4'(LAST_ROUND);

    logic              outValid;
    logic [DATA_W-1:0] outText;
    logic [3:0]        outRound;
    logic              skidValid;
    logic [DATA_W-1:0] skidText;
    logic [3:0]        skidRound;
    logic [3:0]        expRound;
    logic              roundErr;
    logic              doneReg;

    logic              accept;
    logic              transfer;
    logic [DATA_W-1:0] selText;
    logic [DATA_W-1:0] keyedText;

    assign accept   = iValid & ~skidValid;
    assign transfer = outValid & iReady;

    always_comb begin
        if (iRound == 4'd0) begin
            selText = iInText;
        end else if (iRound == LAST) begin
            selText = iShiftText;
        end else begin
            selText = iMixText;
        end
        keyedText = selText ^ iRoundKey;
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            outValid  <= 1'b0;
            outText   <= '0;
            outRound  <= '0;
            skidValid <= 1'b0;
            skidText  <= '0;
            skidRound <= '0;
            expRound  <= '0;
            roundErr  <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= transfer && (outRound == LAST);

            // accept is never true with skidValid set, so skid drain and accept are exclusive
            if (transfer) begin
                if (skidValid) begin
                    outText   <= skidText;
                    outRound  <= skidRound;
                    skidValid <= 1'b0;
                end else if (accept) begin
                    outText  <= keyedText;
                    outRound <= iRound;
                end else begin
                    outValid <= 1'b0;
                end
            end else if (accept) begin
                if (outValid) begin
                    skidText  <= keyedText;
                    skidRound <= iRound;
                    skidValid <= 1'b1;
                end else begin
                    outText  <= keyedText;
                    outRound <= iRound;
                    outValid <= 1'b1;
                end
            end

            if (accept) begin
                if ((iRound == expRound) && (iRound <= LAST)) begin
                    expRound <= (iRound == LAST) ? 4'd0 : iRound + 4'd1;
                end else begin
                    roundErr <= 1'b1;
                    expRound <= (iRound >= LAST) ? 4'd0 : iRound + 4'd1;
                end
            end
        end
    end

    assign oReady     = ~skidValid;
    assign oValid     = outValid;
    assign oRoundText = outText;
    assign oRound     = outRound;
    assign oDone      = doneReg;
    assign oRoundErr  = roundErr;

endmodule
